// File: rtl/seg_display_mux.sv
// seg_display_mux: time-multiplexed driver for a 4-digit common-anode
// seven-segment display fed by a BCD stopwatch counter.
//
// Each digit is driven for REFRESH_DIV clk cycles. The four BCD inputs and
// the decimal-point enables are captured in a snapshot once per frame, at
// the moment the digit index wraps from 3 back to 0. A frame therefore never
// shows a mix of old and new digits. an, seg, dp and frame_tick are all
// registered.
//
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zeros in
// digits 3..1. Digit 0 is never blanked. A blanked slot drives an = 4'b1111.
// Without the macro, no blanking logic is built.
module seg_display_mux #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] reg_d0,
  input  logic [3:0] reg_d1,
  input  logic [3:0] reg_d2,
  input  logic [3:0] reg_d3,
  input  logic [3:0] dp_en,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] refresh_cnt;
  logic [1:0]    digit_idx;
  logic [3:0]    snap_d0;
  logic [3:0]    snap_d1;
  logic [3:0]    snap_d2;
  logic [3:0]    snap_d3;
  logic [3:0]    snap_dp;

  logic          cnt_last;
  logic          frame_wrap;
  logic [3:0]    cur_digit;
  logic          cur_dp;
  logic          digit_blank;
  logic [6:0]    cur_seg;

  // The slot ends on the last refresh count. The frame ends when the last
  // slot of digit 3 ends.
  assign cnt_last   = (refresh_cnt == CNT_LAST);
  assign frame_wrap = cnt_last && (digit_idx == 2'd3);

  // Refresh counter: counts 0..REFRESH_DIV-1, then wraps to 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      refresh_cnt <= '0;
    end else if (cnt_last) begin
      refresh_cnt <= '0;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  // Digit index: advances once per slot and wraps naturally from 3 to 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digit_idx <= 2'd0;
    end else if (cnt_last) begin
      digit_idx <= digit_idx + 2'd1;
    end
  end

  // Snapshot: captured only at a frame boundary. frame_tick is high during
  // the first cycle in which the new snapshot is visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_d0    <= 4'd0;
      snap_d1    <= 4'd0;
      snap_d2    <= 4'd0;
      snap_d3    <= 4'd0;
      snap_dp    <= 4'd0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_wrap;
      if (frame_wrap) begin
        snap_d0 <= reg_d0;
        snap_d1 <= reg_d1;
        snap_d2 <= reg_d2;
        snap_d3 <= reg_d3;
        snap_dp <= dp_en;
      end
    end
  end

  // Select the snapshot digit and decimal-point enable for the current index.
  always_comb begin
    cur_digit = snap_d0;
    cur_dp    = snap_dp[0];
    case (digit_idx)
      2'd0: begin cur_digit = snap_d0; cur_dp = snap_dp[0]; end
      2'd1: begin cur_digit = snap_d1; cur_dp = snap_dp[1]; end
      2'd2: begin cur_digit = snap_d2; cur_dp = snap_dp[2]; end
      2'd3: begin cur_digit = snap_d3; cur_dp = snap_dp[3]; end
      default: begin cur_digit = snap_d0; cur_dp = snap_dp[0]; end
    endcase
  end

  // Decode BCD to active-low {g,f,e,d,c,b,a}. Non-BCD values show a dash.
  always_comb begin
    cur_seg = 7'h3F;
    case (cur_digit)
      4'd0: cur_seg = 7'h40;
      4'd1: cur_seg = 7'h79;
      4'd2: cur_seg = 7'h24;
      4'd3: cur_seg = 7'h30;
      4'd4: cur_seg = 7'h19;
      4'd5: cur_seg = 7'h12;
      4'd6: cur_seg = 7'h02;
      4'd7: cur_seg = 7'h78;
      4'd8: cur_seg = 7'h00;
      4'd9: cur_seg = 7'h10;
      default: cur_seg = 7'h3F;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic lz3;
  logic lz2;
  logic lz1;

  // A digit counts as a leading zero when it and every digit to its left
  // are zero.
  assign lz3 = (snap_d3 == 4'd0);
  assign lz2 = lz3 && (snap_d2 == 4'd0);
  assign lz1 = lz2 && (snap_d1 == 4'd0);

  // Blank the current slot if it holds a leading zero. Digit 0 always shows.
  always_comb begin
    digit_blank = 1'b0;
    case (digit_idx)
      2'd1:    digit_blank = lz1;
      2'd2:    digit_blank = lz2;
      2'd3:    digit_blank = lz3;
      default: digit_blank = 1'b0;
    endcase
  end
`else
  assign digit_blank = 1'b0;
`endif

  // Output registers: one cycle behind the index and snapshot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an  <= 4'b1111;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= digit_blank ? 4'b1111 : ~(4'b0001 << digit_idx);
      seg <= cur_seg;
      dp  <= ~cur_dp;
    end
  end

endmodule

// File: tb/tb_seg_display_mux.sv
// tb_seg_display_mux: self-checking bench for seg_display_mux (REFRESH_DIV=4).
// The reference model works from the number of clock edges since reset was
// released. Each frame is 16 cycles long. The slot is taken from the position
// in the frame, and the snapshot is an array that is refreshed every 16th edge.
module tb_seg_display_mux;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic       clk;
  logic       reset_n;
  logic [3:0] reg_d0, reg_d1, reg_d2, reg_d3;
  logic [3:0] dp_en;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_tick;

  seg_display_mux #(.REFRESH_DIV(DIV)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .reg_d0     (reg_d0),
    .reg_d1     (reg_d1),
    .reg_d2     (reg_d2),
    .reg_d3     (reg_d3),
    .dp_en      (dp_en),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int n      = 0;            // posedges since reset release
  logic [3:0] snap [4];      // model snapshot digits, index = digit number
  logic [3:0] snap_dp;
  logic [6:0] seg_tab [16];
  logic [3:0] an_tab  [4];

  typedef struct packed {
    logic [15:0] digits;     // {d3,d2,d1,d0}
    logic [3:0]  dpe;
    logic [27:0] exp_seg;    // {slot3,slot2,slot1,slot0}
    logic [3:0]  blank_on;   // blanked slots when leading-zero blanking is built
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s n=%0d got %0h expected %0h", name, n, act, exp);
    end
  endtask

  function automatic logic is_blank(input int slot);
    logic all_zero;
    all_zero = 1'b1;
    for (int i = slot; i < 4; i++) if (snap[i] != 4'd0) all_zero = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    return (slot != 0) && all_zero;
`else
    return 1'b0;
`endif
  endfunction

  task automatic set_digits(input logic [15:0] d, input logic [3:0] e);
    reg_d0 = d[3:0];
    reg_d1 = d[7:4];
    reg_d2 = d[11:8];
    reg_d3 = d[15:12];
    dp_en  = e;
  endtask

  task automatic clear_model();
    n = 0;
    for (int i = 0; i < 4; i++) snap[i] = 4'd0;
    snap_dp = 4'd0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_an"},   an,         4'hF);
    chk({tag, "_seg"},  seg,        7'h7F);
    chk({tag, "_dp"},   dp,         1'b1);
    chk({tag, "_tick"}, frame_tick, 1'b0);
  endtask

  // One posedge: compare outputs against the model, then capture the snapshot.
  task automatic step();
    int slot;
    logic blank;
    @(posedge clk);
    n++;
    #1;
    slot  = ((n - 1) % FRAME) / DIV;
    blank = is_blank(slot);
    chk("m_an", an, blank ? 4'hF : an_tab[slot]);
    if (!blank) begin
      chk("m_seg", seg, seg_tab[snap[slot]]);
      chk("m_dp",  dp,  !snap_dp[slot]);
    end
    chk("m_tick", frame_tick, (n % FRAME) == 0);
    if ((n % FRAME) == 0) begin
      snap[0] = reg_d0;
      snap[1] = reg_d1;
      snap[2] = reg_d2;
      snap[3] = reg_d3;
      snap_dp = dp_en;
    end
  endtask

  // Step until a snapshot has been taken. At most one frame.
  task automatic to_snapshot();
    do step(); while ((n % FRAME) != 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    vecs[0] = '{digits:16'h0512, dpe:4'b0100, exp_seg:{7'h40, 7'h12, 7'h79, 7'h24}, blank_on:4'b1000};
    vecs[1] = '{digits:16'h87C6, dpe:4'b0001, exp_seg:{7'h00, 7'h78, 7'h3F, 7'h02}, blank_on:4'b0000};
    vecs[2] = '{digits:16'h0000, dpe:4'b1111, exp_seg:{7'h40, 7'h40, 7'h40, 7'h40}, blank_on:4'b1110};
    vecs[3] = '{digits:16'h0039, dpe:4'b0010, exp_seg:{7'h40, 7'h40, 7'h30, 7'h10}, blank_on:4'b1100};
    vecs[4] = '{digits:16'hFA00, dpe:4'b1000, exp_seg:{7'h3F, 7'h3F, 7'h40, 7'h40}, blank_on:4'b0000};
    vecs[5] = '{digits:16'h1000, dpe:4'b0000, exp_seg:{7'h79, 7'h40, 7'h40, 7'h40}, blank_on:4'b0000};

    // Reset held for 3 cycles, with digits 1,2,3,4 waiting on the inputs.
    reset_n = 1'b0;
    set_digits(16'h1234, 4'b0000);
    clear_model();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_reset_outputs("rst_hold");
    end
    @(negedge clk);
    reset_n = 1'b1;

    // The first frame shows the zero snapshot. frame_tick fires at edge 16.
    step();
    chk("first_an", an, 4'b1110);
    chk("first_seg", seg, 7'h40);
    for (int i = 1; i < FRAME; i++) step();
    chk("tick16", frame_tick, 1'b1);
    for (int k = 0; k < FRAME; k++) begin
      step();
      if (k % DIV == 0) chk("frame2_seg", seg, (k == 0) ? 7'h19 : (k == 4) ? 7'h30 : (k == 8) ? 7'h24 : 7'h79);
    end

    // Table-driven vectors: one full frame per vector.
    foreach (vecs[v]) begin
      logic [3:0] bl;
      int slot;
`ifdef LEADING_ZERO_BLANK_EN
      bl = vecs[v].blank_on;
`else
      bl = 4'b0000;
`endif
      set_digits(vecs[v].digits, vecs[v].dpe);
      to_snapshot();
      set_digits(~vecs[v].digits, ~vecs[v].dpe);   // must not leak into this frame
      for (int k = 0; k < FRAME; k++) begin
        step();
        if (k % DIV == 0) begin
          slot = k / DIV;
          chk("tbl_an", an, bl[slot] ? 4'hF : an_tab[slot]);
          if (!bl[slot]) begin
            chk("tbl_seg", seg, vecs[v].exp_seg[slot*7 +: 7]);
            chk("tbl_dp", dp, !vecs[v].dpe[slot]);
          end
        end
      end
    end

    // Change the inputs from 9999 to 0000 in the middle of a frame.
    set_digits(16'h9999, 4'b0000);
    to_snapshot();
    for (int k = 0; k < 6; k++) step();
    set_digits(16'h0000, 4'b0000);
    for (int k = 6; k < FRAME; k++) begin
      step();
      chk("mid_old_seg", seg, 7'h10);
    end
    for (int k = 0; k < FRAME; k++) begin
      step();
`ifdef LEADING_ZERO_BLANK_EN
      if (k < DIV) chk("mid_new_seg0", seg, 7'h40);
      else chk("mid_new_blank", an, 4'hF);
`else
      chk("mid_new_seg", seg, 7'h40);
`endif
    end

    // Randomised inputs, changed at random points.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 5) == 0) begin
        set_digits(16'($urandom_range(0, 65535)), 4'($urandom_range(0, 15)));
      end
      step();
    end

    // Asynchronous reset at index 2, count 1.
    set_digits(16'h4321, 4'b0101);
    for (int k = 0; k < 2 * FRAME && (n % FRAME) != 9; k++) step();
    chk("async_pos", n % FRAME, 9);
    #3;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async_now");
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check_reset_outputs("async_hold");
    end
    @(negedge clk);
    reset_n = 1'b1;
    clear_model();
    step();
    chk("restart_an", an, 4'b1110);
    chk("restart_seg", seg, 7'h40);
    for (int k = 1; k < 2 * FRAME; k++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Time limit in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout n=%0d got running expected finished", n);
    $fatal(1, "timeout");
  end

endmodule
